// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a valid/ready FIFO, frames stream back-to-back
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int FW = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [FW-1:0]        shift_q, shift_d, frame;
  logic                 tx_q, tx_d, busy_q, busy_d;
  logic                 push, pop, empty, last_cyc;
  logic [DATA_BITS-1:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign empty      = count_q == '0;
  assign in_ready   = count_q != (AW+1)'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign last_cyc   = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // Frame image for the FIFO head, shifted out LSB first: start, data, optional parity, stop bits
  always_comb begin
    frame = '1;
    frame[DATA_BITS:1] = head;
    frame[0] = 1'b0;
    if (PARITY != 0) frame[DATA_BITS+1] = ^head ^ (PARITY == 1);
  end

  // Shifter FSM: bit timing, state sequencing and the pop that starts each frame
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || last_cyc) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = (state_q != S_IDLE && last_cyc) ? {1'b1, shift_q[FW-1:1]} : shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:   pop = !empty;
      S_START:  if (last_cyc) state_d = S_DATA;
      S_DATA:   if (last_cyc) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (last_cyc) state_d = S_STOP;
      S_STOP:   if (last_cyc) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'(STOP_BITS - 1)) begin
          bit_d   = '0;
          state_d = S_IDLE;
          pop     = !empty;
        end
      end
      default:  state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      shift_d = frame;
      cnt_d   = '0;
      bit_d   = '0;
    end
  end

  // FIFO pointers and occupancy; line and busy are registered together so they move on the same edge
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    tx_d     = (state_q == S_IDLE) ? 1'b1 : shift_q[0];
    busy_d   = state_q != S_IDLE;
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge sysclk)
    if (push) mem_q[wr_ptr_q] <= in_data;

  // State registers; reset aborts any frame and forces the line idle without a clock
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for an 8E2 depth-4 instance and a 7O1 depth-8 instance
module tb_uart_tx_fifo;
  logic       sysclk, rst_n;
  logic [7:0] a_data;
  logic       a_valid, a_ready, tx_a, busy_a;
  logic [2:0] cnt_a;
  logic [6:0] b_data;
  logic       b_valid, b_ready, tx_b, busy_b;
  logic [3:0] cnt_b;
  logic [15:0] qa[$], qb[$];
  int n_assert = 0, n_fail = 0, done_a = 0, done_b = 0;
  int acc, w, n;
  logic [7:0] d;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_a (
    .sysclk(sysclk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
    .sysclk(sysclk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // 8E2 frame: start, 8 data LSB first, even parity, two stops
  function automatic logic [15:0] fa(input logic [7:0] v);
    return {4'b0, 2'b11, ^v, v, 1'b0};
  endfunction

  // 7O1 frame: start, 7 data LSB first, odd parity, one stop
  function automatic logic [15:0] fb(input logic [6:0] v);
    return {6'b0, 1'b1, ~^v, v, 1'b0};
  endfunction

  task automatic tick;
    @(negedge sysclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [7:0] v);
    a_data = v;
    a_valid = 1'b1;
    if (a_ready) qa.push_back(fa(v));
    tick();
    a_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [6:0] v);
    b_data = v;
    b_valid = 1'b1;
    if (b_ready) qb.push_back(fb(v));
    tick();
    b_valid = 1'b0;
  endtask

  task automatic busy_len(input bit s, output int len);
    len = 0;
    while ((s ? busy_b : busy_a) && len < 500) begin
      len++;
      tick();
    end
  endtask

  task automatic wait_done(input bit s);
    int i = 0;
    while ((s ? (qb.size() > 0 || busy_b) : (qa.size() > 0 || busy_a)) && i < 2000) begin
      i++;
      tick();
    end
    tick();
    chk(s ? "drain_b_timeout" : "drain_a_timeout", i < 2000, 1);
  endtask

  task automatic lat_a(input logic [7:0] v, input string t);
    int len;
    drive_a(v);
    chk({t, "_cnt_k"}, cnt_a, 1);
    chk({t, "_tx_k"}, tx_a, 1);
    chk({t, "_busy_k"}, busy_a, 0);
    tick();
    chk({t, "_cnt_k1"}, cnt_a, 0);
    chk({t, "_tx_k1"}, tx_a, 1);
    chk({t, "_busy_k1"}, busy_a, 0);
    tick();
    chk({t, "_tx_k2"}, tx_a, 0);
    chk({t, "_busy_k2"}, busy_a, 1);
    busy_len(1'b0, len);
    chk({t, "_busy_len"}, len, 48);
    wait_done(1'b0);
  endtask

  // Line monitor: on each start bit pop the expected frame and check every cycle of every bit
  task automatic monitor(input bit s);
    logic [15:0] exp, obs;
    int nb, bad;
    bit abort;
    nb = s ? 10 : 12;
    forever begin
      @(negedge sysclk);
      if (rst_n && (s ? tx_b : tx_a) === 1'b0) begin
        n_assert++;
        assert ((s ? qb.size() : qa.size()) > 0) else begin
          n_fail++;
          $error("FAIL unexpected_frame_%0d: observed start bit, expected idle line", s);
        end
        exp = '1;
        if (s && qb.size() > 0) exp = qb.pop_front();
        if (!s && qa.size() > 0) exp = qa.pop_front();
        bad = 0;
        obs = '0;
        abort = 1'b0;
        for (int j = 0; j < nb * 4; j++) begin
          if (j > 0) @(negedge sysclk);
          if (!rst_n) begin
            abort = 1'b1;
            break;
          end
          obs[j/4] = s ? tx_b : tx_a;
          if (obs[j/4] !== exp[j/4]) bad++;
        end
        if (!abort) begin
          if (s) done_b++;
          else done_a++;
          n_assert++;
          assert (bad == 0) else begin
            n_fail++;
            $error("FAIL frame_%0d: observed %h expected %h (%0d bad cycles)", s, obs, exp, bad);
          end
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data = '0;
    b_data = '0;
    repeat (3) tick();
    chk("reset_tx_a", tx_a, 1);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_ready_a", a_ready, 1);
    chk("reset_count_a", cnt_a, 0);
    chk("reset_tx_b", tx_b, 1);
    rst_n = 1'b1;
    tick();

    lat_a(8'h41, "single");

    drive_b(7'h41);
    drive_b(7'h07);
    chk("b_count_k1", cnt_b, 1);
    chk("b_tx_k1", tx_b, 1);
    tick();
    chk("b_tx_k2", tx_b, 0);
    chk("b_busy_k2", busy_b, 1);
    busy_len(1'b1, n);
    chk("b_busy_len", n, 80);
    wait_done(1'b1);

    drive_a(8'h55);
    drive_a(8'hAA);
    chk("b2b_tx_k1", tx_a, 1);
    tick();
    chk("b2b_tx_k2", tx_a, 0);
    busy_len(1'b0, n);
    chk("b2b_busy_len", n, 96);
    wait_done(1'b0);

    d = 8'h10;
    acc = 0;
    a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = d;
      if (a_ready) begin
        qa.push_back(fa(d));
        d++;
        acc++;
      end
      tick();
    end
    a_valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_ready", a_ready, 0);
    chk("full_count", cnt_a, 4);
    w = 0;
    while (cnt_a == 3'd4 && w < 200) begin
      w++;
      tick();
    end
    chk("full_pop_count", cnt_a, 3);
    chk("full_ready_back", a_ready, 1);
    repeat (48) tick();
    chk("count_after_pop2", cnt_a, 2);
    repeat (47) tick();
    a_data = 8'h15;
    a_valid = 1'b1;
    if (a_ready) qa.push_back(fa(8'h15));
    tick();
    a_valid = 1'b0;
    chk("simul_push_pop_count", cnt_a, 2);
    wait_done(1'b0);

    drive_a(8'h31);
    drive_a(8'h32);
    drive_a(8'h33);
    drive_a(8'h34);
    chk("abort_start_bit", tx_a, 0);
    chk("abort_queued", cnt_a, 3);
    repeat (16) tick();
    chk("tx_before_abort", tx_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_count", cnt_a, 0);
    chk("abort_ready", a_ready, 1);
    qa.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lat_a(8'h5A, "post_reset");

    chk("frames_a", done_a, 10);
    chk("frames_b", done_b, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
